fft_frame_ctrl: RTL and testbench

//  Frame sequencer in front of the fft_8192 wrapper. Per i_start it issues one config beat,

---
 rtl/fft_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl
//   Frame sequencer that sits between the ADC capture stream and the FFT core.
//   Each accepted i_start produces one config beat (direction), then exactly
//   2**LOG2_N input beats with a generated tlast. The controller then follows
//   the output frame until its tlast and captures the block exponent. Core
//   alarms are latched, and the core is held in reset for 4 cycles after an
//   abort or a watchdog timeout.
//
// Ports
//   i_aclk / i_aresetn         clock, async active-low reset
//   i_start, i_inverse         frame request (IDLE only); 1 = IFFT
//   i_abort                    drop the current frame and reset the core
//   i_s_*  / o_s_tready        capture stream in
//   o_fft_aresetn              core reset (low in RECOVER)
//   o_fft_cfg_*                one-beat config, tdata 1 = forward
//   o_fft_t*  / i_fft_tready   core data in (pass-through while loading)
//   i_fft_out_*                core data out monitor (valid/last/user)
//   i_fft_alm                  core alarms, [1:0] latched
//   o_busy, o_done             status; done is a 1-cycle pulse
//   o_err                      sticky {timeout, len_err, alm[1:0]}
//   o_blk_exp                  tuser[7:0] of the output tlast beat
// ---------------------------------------------------------------------------
module fft_frame_ctrl #(
  parameter int LOG2_N    = 13,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 24,
  parameter int TIMEOUT_W = 20
) (
  input  logic              i_aclk,
  input  logic              i_aresetn,
  input  logic              i_start,
  input  logic              i_inverse,
  input  logic              i_abort,
  input  logic              i_s_tvalid,
  input  logic [DATA_W-1:0] i_s_tdata,
  output logic              o_s_tready,
  output logic              o_fft_aresetn,
  output logic              o_fft_cfg_tvalid,
  output logic              o_fft_cfg_tdata,
  output logic              o_fft_tvalid,
  output logic [DATA_W-1:0] o_fft_tdata,
  output logic              o_fft_tlast,
  input  logic              i_fft_tready,
  input  logic              i_fft_out_tvalid,
  input  logic              i_fft_out_tlast,
  input  logic [USER_W-1:0] i_fft_out_tuser,
  input  logic [2:0]        i_fft_alm,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_err,
  output logic [7:0]        o_blk_exp
);

  localparam logic [LOG2_N-1:0] LAST_IDX = '1;
  // The watchdog fires on the (2**TIMEOUT_W-1)-th consecutive idle cycle,
  // i.e. while the counter still holds 2**TIMEOUT_W-2 idle cycles behind it.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE, CFG, LOAD, WAIT_OUT, DONE, RECOVER
  } state_t;

  state_t                state, state_nxt;
  logic [LOG2_N-1:0]     in_cnt, out_cnt;
  logic [TIMEOUT_W-1:0]  wd_cnt;
  logic [1:0]            rec_cnt;
  logic                  cfg_fwd;
  logic [3:0]            err;
  logic [7:0]            blk_exp;

  logic in_hs, out_beat, wd_en, wd_fire;

  // Bits of the core sideband this block does not use.
  logic unused_sideband;
  assign unused_sideband = ^{i_fft_alm[2], i_fft_out_tuser[USER_W-1:8]};

  assign in_hs    = (state == LOAD) && i_s_tvalid && i_fft_tready;
  assign out_beat = (state == WAIT_OUT) && i_fft_out_tvalid;
  assign wd_en    = (state == LOAD) || (state == WAIT_OUT);
  assign wd_fire  = wd_en && !in_hs && !out_beat && (wd_cnt == WD_LAST);

  // next state and outputs
  always_comb begin
    state_nxt        = state;
    o_busy           = (state != IDLE);
    o_done           = 1'b0;
    o_fft_aresetn    = 1'b1;
    o_fft_cfg_tvalid = 1'b0;
    o_fft_cfg_tdata  = cfg_fwd;
    o_fft_tvalid     = 1'b0;
    o_s_tready       = 1'b0;
    o_fft_tdata      = '0;
    o_fft_tlast      = 1'b0;
    o_err            = err;
    o_blk_exp        = blk_exp;

    case (state)
      IDLE: if (i_start) state_nxt = CFG;
      CFG: begin
        o_fft_cfg_tvalid = 1'b1;
        state_nxt        = LOAD;
      end
      LOAD: begin
        o_fft_tvalid = i_s_tvalid;
        o_s_tready   = i_fft_tready;
        o_fft_tdata  = i_s_tdata;
        o_fft_tlast  = (in_cnt == LAST_IDX);
        if (in_hs && in_cnt == LAST_IDX) state_nxt = WAIT_OUT;
      end
      WAIT_OUT: if (out_beat && i_fft_out_tlast) state_nxt = DONE;
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      RECOVER: begin
        o_fft_aresetn = 1'b0;
        if (rec_cnt == 2'd3) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (wd_fire) state_nxt = RECOVER;
    // Abort wins over everything, including a handshake in the same cycle;
    // an abort during RECOVER restarts the reset hold.
    if (i_abort && state != IDLE) state_nxt = RECOVER;
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      wd_cnt  <= '0;
      rec_cnt <= '0;
      cfg_fwd <= 1'b0;
      err     <= '0;
      blk_exp <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && i_start) begin
        cfg_fwd <= ~i_inverse;
        err     <= '0;
      end

      // Counters restart for every frame; they wrap on their own width.
      if (state == CFG) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else if (!i_abort) begin
        if (in_hs)    in_cnt  <= in_cnt + 1'b1;
        if (out_beat) out_cnt <= out_cnt + 1'b1;
      end

      if (!wd_en || in_hs || out_beat) wd_cnt <= '0;
      else                             wd_cnt <= wd_cnt + 1'b1;

      rec_cnt <= (state == RECOVER && !i_abort) ? rec_cnt + 2'd1 : 2'd0;

      if (state != IDLE) err[1:0] <= err[1:0] | i_fft_alm[1:0];
      if (wd_fire)       err[3]   <= 1'b1;

      if (out_beat && i_fft_out_tlast && !i_abort) begin
        blk_exp <= i_fft_out_tuser[7:0];
        if (out_cnt != LAST_IDX) err[2] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
module tb_fft_frame_ctrl;
  localparam int LOG2_N    = 13;
  localparam int DATA_W    = 32;
  localparam int USER_W    = 24;
  localparam int TIMEOUT_W = 6;
  localparam int N         = 1 << LOG2_N;
  localparam int WD_TERM   = (1 << TIMEOUT_W) - 1;

  logic              i_aclk = 1'b0;
  logic              i_aresetn = 1'b0;
  logic              i_start = 1'b0, i_inverse = 1'b0, i_abort = 1'b0;
  logic              i_s_tvalid = 1'b0;
  logic [DATA_W-1:0] i_s_tdata = '0;
  logic              o_s_tready, o_fft_aresetn, o_fft_cfg_tvalid, o_fft_cfg_tdata;
  logic              o_fft_tvalid, o_fft_tlast;
  logic [DATA_W-1:0] o_fft_tdata;
  logic              i_fft_tready = 1'b0;
  logic              i_fft_out_tvalid = 1'b0, i_fft_out_tlast = 1'b0;
  logic [USER_W-1:0] i_fft_out_tuser = '0;
  logic [2:0]        i_fft_alm = '0;
  logic              o_busy, o_done;
  logic [3:0]        o_err;
  logic [7:0]        o_blk_exp;

  fft_frame_ctrl #(.LOG2_N(LOG2_N), .DATA_W(DATA_W), .USER_W(USER_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .i_aclk(i_aclk), .i_aresetn(i_aresetn), .i_start(i_start), .i_inverse(i_inverse),
    .i_abort(i_abort), .i_s_tvalid(i_s_tvalid), .i_s_tdata(i_s_tdata), .o_s_tready(o_s_tready),
    .o_fft_aresetn(o_fft_aresetn), .o_fft_cfg_tvalid(o_fft_cfg_tvalid),
    .o_fft_cfg_tdata(o_fft_cfg_tdata), .o_fft_tvalid(o_fft_tvalid), .o_fft_tdata(o_fft_tdata),
    .o_fft_tlast(o_fft_tlast), .i_fft_tready(i_fft_tready), .i_fft_out_tvalid(i_fft_out_tvalid),
    .i_fft_out_tlast(i_fft_out_tlast), .i_fft_out_tuser(i_fft_out_tuser), .i_fft_alm(i_fft_alm),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_blk_exp(o_blk_exp));

  always #5 i_aclk = ~i_aclk;

  int         n_vec = 0, n_err = 0;
  string      cur = "rst";
  logic [7:0] exp_blk = '0;   // o_blk_exp only changes on a completed output frame

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_start = 0; i_abort = 0; i_s_tvalid = 0; i_fft_out_tvalid = 0;
    i_fft_out_tlast = 0; i_fft_alm = 0;
  endtask

  // One frame from i_start to return to IDLE. The reference is a count-based
  // view of the frame: input beats taken, output beats seen, consecutive idle
  // cycles, and which error bits the frame's events must leave behind.
  //   vprob8   : chance/8 that source tvalid (and core out tvalid) is high
  //   rtoggle  : core tready alternates every cycle instead of staying high
  //   out_len  : output beat index+1 carrying tlast
  //   abort_at : input beat count at which abort is raised (-1 = never)
  //   alm_at   : input beat count at which alm=010 pulses; stray starts follow
  //   stall    : source never valid (watchdog path)
  //   noise    : random core-out beats while still loading
  task automatic run_frame(input string name, input bit inv, input int vprob8, input bit rtoggle,
                           input int out_len, input int abort_at, input int alm_at,
                           input bit stall, input bit noise);
    int         phase, n_in, n_out, idle, rec, cyc;
    bit         alm_fired, fin;
    logic [3:0] exp_err;
    phase = 0; n_in = 0; n_out = 0; idle = 0; rec = 0; cyc = 0;
    alm_fired = 0; fin = 0; exp_err = '0;
    cur = name;

    @(posedge i_aclk); #1;
    idle_inputs(); i_start = 1; i_inverse = inv;
    @(negedge i_aclk);
    chk("pre_start", {o_busy, o_fft_cfg_tvalid}, 2'b00);
    @(posedge i_aclk); #1;
    i_start = 0; i_inverse = ~inv;
    @(negedge i_aclk);
    chk("cfg", {o_busy, o_fft_cfg_tvalid, o_fft_cfg_tdata, o_err}, {1'b1, 1'b1, ~inv, 4'b0000});

    while (!fin && cyc < 40000) begin
      cyc++;
      @(posedge i_aclk); #1;
      idle_inputs();
      i_s_tdata       = $urandom;
      i_fft_out_tuser = $urandom;
      i_s_tvalid      = !stall && ($urandom_range(0, 7) < vprob8);
      i_fft_tready    = rtoggle ? ~i_fft_tready : 1'b1;
      if (phase == 0) begin
        if (noise) begin
          i_fft_out_tvalid = $urandom_range(0, 1);
          i_fft_out_tlast  = $urandom_range(0, 1);
        end
        if (n_in == abort_at) begin
          i_abort = 1; i_s_tvalid = 1; i_fft_tready = 1;
        end
        if (n_in == alm_at && !alm_fired) begin
          i_fft_alm = 3'b010; alm_fired = 1;
        end
        if (alm_at >= 0 && n_in > alm_at) i_start = $urandom_range(0, 1);
      end else if (phase == 1) begin
        i_fft_out_tvalid = ($urandom_range(0, 7) < vprob8);
        i_fft_out_tlast  = i_fft_out_tvalid && (n_out == out_len - 1);
      end
      @(negedge i_aclk);
      case (phase)
        0: begin
          chk("load_if", {o_fft_tvalid, o_s_tready, o_done, o_fft_aresetn},
              {i_s_tvalid, i_fft_tready, 1'b0, 1'b1});
          exp_err[1:0] = exp_err[1:0] | i_fft_alm[1:0];
          if (i_abort) phase = 3;
          else if (i_s_tvalid && i_fft_tready) begin
            chk("tdata", o_fft_tdata, i_s_tdata);
            chk("tlast", o_fft_tlast, n_in == N - 1);
            n_in++; idle = 0;
            if (n_in == N) phase = 1;
          end else begin
            idle++;
            if (idle == WD_TERM) begin exp_err[3] = 1; phase = 3; end
          end
        end
        1: begin
          chk("wait_if", {o_fft_tvalid, o_s_tready, o_done, o_busy}, 4'b0001);
          if (i_fft_out_tvalid) begin
            idle = 0;
            if (i_fft_out_tlast) begin
              exp_blk = i_fft_out_tuser[7:0];
              if (n_out != N - 1) exp_err[2] = 1;
              phase = 2;
            end
            n_out++;
          end else begin
            idle++;
            if (idle == WD_TERM) begin exp_err[3] = 1; phase = 3; end
          end
        end
        2: begin
          chk("done", {o_done, o_busy, o_fft_aresetn, o_err, o_blk_exp},
              {1'b1, 1'b1, 1'b1, exp_err, exp_blk});
          fin = 1;
        end
        default: begin
          rec++;
          chk("recover", {o_fft_aresetn, o_busy, o_done, o_fft_tvalid, o_s_tready}, 5'b01000);
          if (rec == 4) fin = 1;
        end
      endcase
    end
    chk("frame_budget", fin, 1'b1);

    @(posedge i_aclk); #1;
    idle_inputs();
    @(negedge i_aclk);
    chk("end_idle", {o_busy, o_done, o_fft_aresetn, o_err, o_blk_exp},
        {1'b0, 1'b0, 1'b1, exp_err, exp_blk});
  endtask

  initial begin
    #1;
    chk("rst_ctrl", {o_busy, o_done, o_fft_aresetn, o_fft_cfg_tvalid, o_fft_cfg_tdata,
                     o_fft_tvalid, o_s_tready, o_fft_tlast}, 8'b0010_0000);
    chk("rst_data", {o_err, o_blk_exp, o_fft_tdata}, 44'h0);
    #20;
    @(negedge i_aclk); i_aresetn = 1;

    // abort and a stray output tlast in IDLE must do nothing
    cur = "idle";
    @(posedge i_aclk); #1;
    i_abort = 1; i_fft_out_tvalid = 1; i_fft_out_tlast = 1;
    @(negedge i_aclk);
    @(posedge i_aclk); #1;
    idle_inputs();
    @(negedge i_aclk);
    chk("idle_abort", {o_busy, o_fft_aresetn, o_done, o_err}, 7'b0100000);

    run_frame("t1_basic",   1'b0, 8, 1'b0, N,   -1,   -1,   1'b0, 1'b0);
    run_frame("t2_toggle",  1'b1, 7, 1'b1, N,   -1,   -1,   1'b0, 1'b1);
    run_frame("t3_short",   1'b0, 8, 1'b0, 101, -1,   -1,   1'b0, 1'b0);
    run_frame("t4_abort",   1'b1, 8, 1'b0, N,   4000, -1,   1'b0, 1'b0);
    run_frame("t6_alarm",   1'b0, 8, 1'b0, N,   -1,   2000, 1'b0, 1'b0);
    run_frame("t5_timeout", 1'b0, 8, 1'b0, N,   -1,   -1,   1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete, vectors %0d", n_vec);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
